// File: rtl/wish_slave_bridge.sv
// wish_slave_bridge: Wishbone classic slave turning each transfer into one memory strobe plus MEM_LAT wait cycles.
// Define WISH_ERR_EN to terminate out-of-range addresses with err instead of wrapping them.
module wish_slave_bridge #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cyc,
    input  logic            stb,
    input  logic            we,
    input  logic [DW/8-1:0] sel,
    input  logic [AW-1:0]   ADR_I,
    input  logic [DW-1:0]   DAT_I,
    output logic            ack,
`ifdef WISH_ERR_EN
    output logic            err,
`endif
    output logic [DW-1:0]   DAT_O,
    output logic            read_en,
    output logic            write_en,
    output logic [AW-1:0]   ADR_STR,
    output logic [DW-1:0]   DAT_STR,
    output logic [DW/8-1:0] BE_STR,
    input  logic [DW-1:0]   DAT_mem_to_reg
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    localparam logic [AW:0] BYTES = (AW+1)'(DEPTH * (DW / 8));
    localparam logic [3:0]  LAST  = 4'(MEM_LAT == 0 ? 0 : MEM_LAT - 1);
    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          we_r, req, oob, capture;
    logic [AW-1:0] adr_l;
    assign req = cyc & stb;
`ifdef WISH_ERR_EN
    assign oob   = {1'b0, ADR_I} >= BYTES;
    assign adr_l = ADR_I;
`else
    assign oob   = 1'b0;
    assign adr_l = AW'({1'b0, ADR_I} % BYTES);
`endif
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:   state_nxt = req ? (oob ? RESP : ACCESS) : IDLE;
            ACCESS: state_nxt = !cyc ? IDLE : (MEM_LAT == 0 ? RESP : WAIT);
            WAIT: begin
                state_nxt = !cyc ? IDLE : (cnt == LAST ? RESP : WAIT);
                cnt_nxt   = (!cyc || cnt == LAST) ? 4'd0 : cnt + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // read data is taken on the edge leaving the last memory cycle, unless the master walked away
    assign capture  = !we_r && cyc && ((state == ACCESS && MEM_LAT == 0) || (state == WAIT && cnt == LAST));
    assign read_en  = state == ACCESS && !we_r;
    assign write_en = state == ACCESS && we_r;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_r    <= 1'b0;
            DAT_O   <= '0;
            ADR_STR <= '0;
            DAT_STR <= '0;
            BE_STR  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                ADR_STR <= adr_l;
                DAT_STR <= DAT_I;
                BE_STR  <= sel;
                we_r    <= we;
            end
            if (capture) DAT_O <= DAT_mem_to_reg;
        end
    end
`ifdef WISH_ERR_EN
    logic err_r;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_r <= 1'b0;
        else if (state == IDLE && req) err_r <= oob;
    end
    assign ack = state == RESP && !err_r;
    assign err = state == RESP && err_r;
`else
    assign ack = state == RESP;
`endif
endmodule

// File: tb/tb_wish_slave_bridge.sv
// tb_wish_slave_bridge: directed bench over three bridges sharing one bus, with MEM_LAT 1, 0 and 3.
module tb_wish_slave_bridge;
    logic        clk = 0, reset = 0, cyc = 0, stb = 0, we = 0;
    logic [3:0]  sel = 0;
    logic [31:0] adr_i = 0, dat_i = 0, mem_rd = 0;
    logic        ack_v[3], err_v[3], re_v[3], wr_v[3];
    logic [31:0] dat_o_v[3], adr_s_v[3], dat_s_v[3];
    logic [3:0]  be_v[3];
    int vec = 0, bad = 0;
    int ack_at, ack_cnt, err_at, err_cnt, we_cnt, re_cnt;
    logic [31:0] s_adr, s_dat, s_dout;
    logic [3:0]  s_be;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wish_slave_bridge #(.MEM_LAT(g == 0 ? 1 : (g == 1 ? 0 : 3))) u (
            .clk(clk), .reset(reset), .cyc(cyc), .stb(stb), .we(we), .sel(sel),
            .ADR_I(adr_i), .DAT_I(dat_i), .ack(ack_v[g]),
`ifdef WISH_ERR_EN
            .err(err_v[g]),
`endif
            .DAT_O(dat_o_v[g]), .read_en(re_v[g]), .write_en(wr_v[g]),
            .ADR_STR(adr_s_v[g]), .DAT_STR(dat_s_v[g]), .BE_STR(be_v[g]),
            .DAT_mem_to_reg(mem_rd));
    end
`ifndef WISH_ERR_EN
    initial for (int i = 0; i < 3; i++) err_v[i] = 1'b0;
`endif

    task automatic do_reset();
        reset = 0; cyc = 0; stb = 0;
        @(negedge clk); @(negedge clk);
        reset = 1;
    endtask

    // one request from a negedge; records what instance i shows over n cycles, scrambles the bus
    // after the first cycle and drops the request on termination or at cycle drop_at
    task automatic run(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int n, input int drop_at);
        cyc = 1; stb = 1; we = w; adr_i = a; dat_i = d; sel = s;
        ack_at = 0; ack_cnt = 0; err_at = 0; err_cnt = 0; we_cnt = 0; re_cnt = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (ack_v[i]) begin ack_cnt++; if (ack_at == 0) ack_at = k; s_dout = dat_o_v[i]; end
            if (err_v[i]) begin err_cnt++; if (err_at == 0) err_at = k; end
            if (wr_v[i]) begin we_cnt++; s_adr = adr_s_v[i]; s_dat = dat_s_v[i]; s_be = be_v[i]; end
            if (re_v[i]) begin re_cnt++; s_adr = adr_s_v[i]; end
            if (k == 1) begin adr_i = ~a; dat_i = ~d; sel = ~s; end
            if (ack_v[i] || err_v[i] || k == drop_at) begin cyc = 0; stb = 0; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vec++; if (ack_v[0] !== 1'b0) begin bad++; $display("FAIL rst_ack got %b exp 0", ack_v[0]); end
        vec++; if ({re_v[0], wr_v[0]} !== 2'b00) begin bad++; $display("FAIL rst_strobes got %b exp 00", {re_v[0], wr_v[0]}); end
        vec++; if (dat_o_v[0] !== 32'h0) begin bad++; $display("FAIL rst_dat_o got %h exp 0", dat_o_v[0]); end
        vec++; if ({adr_s_v[0], dat_s_v[0], be_v[0]} !== 68'h0) begin bad++; $display("FAIL rst_latches got %h/%h/%h exp 0", adr_s_v[0], dat_s_v[0], be_v[0]); end
        reset = 1;
    endtask

    task automatic test_write();
        do_reset();
        run(0, 1, 32'h04, 32'hAB, 4'hF, 6, 0);
        vec++; if (we_cnt !== 1 || re_cnt !== 0) begin bad++; $display("FAIL wr_strobes got we=%0d re=%0d exp 1/0", we_cnt, re_cnt); end
        vec++; if (s_adr !== 32'h04 || s_dat !== 32'hAB || s_be !== 4'hF) begin bad++; $display("FAIL wr_latch got %h/%h/%h exp 4/ab/f", s_adr, s_dat, s_be); end
        vec++; if (ack_at !== 3 || ack_cnt !== 1) begin bad++; $display("FAIL wr_ack got at=%0d n=%0d exp 3/1", ack_at, ack_cnt); end
    endtask

    task automatic test_read();
        do_reset();
        mem_rd = 32'hAA;
        run(0, 0, 32'h08, 32'h0, 4'hF, 6, 0);
        vec++; if (re_cnt !== 1 || we_cnt !== 0) begin bad++; $display("FAIL rd_strobes got re=%0d we=%0d exp 1/0", re_cnt, we_cnt); end
        vec++; if (s_adr !== 32'h08) begin bad++; $display("FAIL rd_adr got %h exp 8", s_adr); end
        vec++; if (ack_at !== 3 || s_dout !== 32'hAA) begin bad++; $display("FAIL rd_ack got at=%0d d=%h exp 3/aa", ack_at, s_dout); end
        mem_rd = 32'h55;
        @(negedge clk); @(negedge clk);
        vec++; if (dat_o_v[0] !== 32'hAA) begin bad++; $display("FAIL rd_hold got %h exp aa", dat_o_v[0]); end
    endtask

    task automatic test_back_to_back();
        int acks[2], n_ack = 0, n_we = 0;
        logic [3:0] bes[2];
        do_reset();
        cyc = 1; stb = 1; we = 1; adr_i = 32'h10; dat_i = 32'h11; sel = 4'h2;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (wr_v[1]) begin if (n_we < 2) bes[n_we] = be_v[1]; n_we++; end
            if (ack_v[1]) begin if (n_ack < 2) acks[n_ack] = k; n_ack++; end
            if (k == 2) begin sel = 4'h8; dat_i = 32'h22; adr_i = 32'h14; end
            if (k == 5) begin cyc = 0; stb = 0; end
        end
        vec++; if (n_ack !== 2 || n_we !== 2) begin bad++; $display("FAIL b2b_counts got ack=%0d we=%0d exp 2/2", n_ack, n_we); end
        vec++; if (n_ack == 2 && (acks[0] !== 2 || acks[1] !== 5)) begin bad++; $display("FAIL b2b_ack_cycles got %0d,%0d exp 2,5", acks[0], acks[1]); end
        vec++; if (n_we == 2 && (bes[0] !== 4'h2 || bes[1] !== 4'h8)) begin bad++; $display("FAIL b2b_be got %h,%h exp 2,8", bes[0], bes[1]); end
    endtask

    task automatic test_range();
        do_reset();
        run(0, 1, 32'h400, 32'h5, 4'hF, 6, 0);
`ifdef WISH_ERR_EN
        vec++; if (err_cnt !== 1 || err_at !== 1) begin bad++; $display("FAIL oob_err got at=%0d n=%0d exp 1/1", err_at, err_cnt); end
        vec++; if (we_cnt !== 0 || ack_cnt !== 0) begin bad++; $display("FAIL oob_quiet got we=%0d ack=%0d exp 0/0", we_cnt, ack_cnt); end
`else
        vec++; if (we_cnt !== 1 || s_adr !== 32'h0) begin bad++; $display("FAIL wrap_write got we=%0d adr=%h exp 1/0", we_cnt, s_adr); end
        vec++; if (ack_at !== 3 || err_cnt !== 0) begin bad++; $display("FAIL wrap_ack got at=%0d err=%0d exp 3/0", ack_at, err_cnt); end
`endif
    endtask

    task automatic test_abort();
        do_reset();
        mem_rd = 32'h33;
        run(2, 0, 32'h10, 32'h0, 4'hF, 7, 0);
        vec++; if (ack_at !== 5 || s_dout !== 32'h33) begin bad++; $display("FAIL lat3_read got at=%0d d=%h exp 5/33", ack_at, s_dout); end
        mem_rd = 32'h99;
        run(2, 0, 32'h14, 32'h0, 4'hF, 8, 2);
        vec++; if (ack_cnt !== 0 || re_cnt !== 1) begin bad++; $display("FAIL abort_ack got ack=%0d re=%0d exp 0/1", ack_cnt, re_cnt); end
        vec++; if (dat_o_v[2] !== 32'h33) begin bad++; $display("FAIL abort_dat_o got %h exp 33", dat_o_v[2]); end
        mem_rd = 32'h44;
        run(2, 0, 32'h18, 32'h0, 4'hF, 7, 0);
        vec++; if (ack_at !== 5 || s_dout !== 32'h44) begin bad++; $display("FAIL after_abort got at=%0d d=%h exp 5/44", ack_at, s_dout); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_rd = 32'h5A;
        run(2, 0, 32'h20, 32'h0, 4'hF, 7, 0);
        mem_rd = 32'h66;
        run(2, 0, 32'h24, 32'h0, 4'hF, 2, 0);
        reset = 0;
        #1;
        vec++; if (dat_o_v[2] !== 32'h0 || adr_s_v[2] !== 32'h0) begin bad++; $display("FAIL midrst_regs got %h/%h exp 0/0", dat_o_v[2], adr_s_v[2]); end
        vec++; if ({ack_v[2], re_v[2], wr_v[2], be_v[2]} !== 7'h0) begin bad++; $display("FAIL midrst_outs got %b exp 0", {ack_v[2], re_v[2], wr_v[2], be_v[2]}); end
        cyc = 0; stb = 0;
        @(negedge clk); @(negedge clk);
        reset = 1;
        mem_rd = 32'h77;
        run(2, 0, 32'h28, 32'h0, 4'hF, 7, 0);
        vec++; if (ack_at !== 5 || s_dout !== 32'h77 || ack_cnt !== 1) begin bad++; $display("FAIL midrst_resume got at=%0d d=%h n=%0d exp 5/77/1", ack_at, s_dout, ack_cnt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_range();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
